tube_scheduler: RTL and testbench
=================================

Name: tube_scheduler

Overview:
Controller that sequences the three-slot tube datapath feeding the frame renderer's tube_x/gap_y inputs. Handles spawn, per-frame scrolling, recycling of tubes that leave the left edge, pseudo-random gap placement and score pulses.
Runs a small game-phase FSM (idle/load/run/frozen) driven by start/freeze from the game top level. All outputs are registered.

Parameters:
SCREEN_W, 1024, visible width; tube_x >= SCREEN_W is not drawn
TUBE_WIDTH, 120, tube width in pixels
TUBE_SPACING, 400, horizontal distance between consecutive tubes
GAP_MIN, 80, smallest gap_y
GAP_RANGE, 480, gap_y span; gap_y in [GAP_MIN, GAP_MIN+GAP_RANGE-1]
BIRD_X, 180, bird column used for scoring
SPEED_INIT, 2, pixels scrolled per frame
LFSR_SEED, 16'hACE1, LFSR reset value (must be non-zero)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
frame_tick  in  1  one-cycle pulse per frame (vblank start)
start  in  1  level; begin or restart a round
freeze  in  1  level; pause scrolling (bird pending/respawn)
tube_x[2:0]  out  3x11  tube left edges
gap_y[2:0]  out  3x11  tube gap tops
score_pulse  out  1  one-cycle pulse per tube passed
running  out  1  high in RUN

Behaviour:
- Reset (async, rst_n low):
  - state IDLE; tube_x[*] = 11'h7FF (parked, invisible); gap_y[*] = GAP_MIN.
  - score_pulse 0; running 0; lfsr = LFSR_SEED; speed = SPEED_INIT.
  - Reset mid-round aborts immediately to these values.
- LFSR: 16-bit Galois, mask 16'hB400, shifts every clock in every state.
  - New gap = GAP_MIN + r, where r = lfsr[8:0]; if r >= GAP_RANGE then r -= GAP_RANGE.
- FSM:
  - IDLE: start=1 -> LOAD. frame_tick and freeze are ignored.
  - LOAD: 3 cycles, one slot per cycle (k=0,1,2).
    - tube_x[k] = SCREEN_W + k*TUBE_SPACING (1024, 1424, 1824).
    - gap_y[k] = new gap.
    - After slot 2 -> RUN. frame_tick during LOAD is dropped.
  - RUN: running=1. freeze=1 -> FROZEN (takes priority over a same-cycle tick; no scroll that cycle). start=1 -> LOAD (restart).
  - FROZEN: outputs hold. freeze=0 -> RUN. start=1 -> LOAD (start beats freeze).
- Scroll, on frame_tick in RUN; results visible the next cycle:
  - For each slot with x >= speed: x_new = x - speed.
  - Recycle: a slot with x < speed takes x_new = (updated x of slot (k+2)%3) + TUBE_SPACING, plus a new gap_y. Because spacing exceeds speed, at most one slot recycles per tick.
  - Arithmetic is 12-bit internally; results always fit in 11 bits.
- Score, evaluated per slot on the same tick:
  - Condition: (x + TUBE_WIDTH) > BIRD_X and (x_new + TUBE_WIDTH) <= BIRD_X, non-recycled slots only.
  - score_pulse is high for exactly the cycle after the tick. Multiple hits in one tick still give one pulse.
- Simultaneous start + freeze in IDLE: start wins -> LOAD; freeze is first honoured in RUN.

Optional Feature:
Macro TUBE_SPEEDUP_EN.
- Defined: internal 4-bit score counter; every 8th score_pulse increments speed, saturating at 6. speed resets to SPEED_INIT on reset and on entry to LOAD.
- Undefined: speed is constant SPEED_INIT; no counter logic.

Test Plan:
- Reset -> tube_x all 2047, gap_y all 80, running 0, score_pulse 0; frame_tick ignored in IDLE.
- start pulse -> 4 cycles later running=1, tube_x = {1024, 1424, 1824}; every gap_y within [80, 559].
- 1 frame_tick in RUN -> next cycle tube_x = {1022, 1422, 1822}.
- 513 ticks after start -> slot0 recycles: tube_x[0] = 1198, tube_x[2] = 798, gap_y[0] refreshed. score_pulse seen exactly once by then, the cycle after tick 482 (slot0 x 62 -> 60).
- freeze=1 for 10 ticks -> tube_x unchanged, running 0; freeze=0 -> next tick scrolls by 2. start while FROZEN -> LOAD values restored.
- rst_n low mid-RUN (asynchronous, between edges) -> outputs immediately at reset values; LFSR back to 16'hACE1.

Source files
------------

// File: rtl/tube_scheduler.sv
// Tube scheduler: game-phase FSM driving the three-slot tube scroll/recycle datapath.
// Optional macro TUBE_SPEEDUP_EN: speed steps up every 8th scored tube, saturating at 6.
module tube_scheduler #(
    parameter int          SCREEN_W     = 1024,
    parameter int          TUBE_WIDTH   = 120,
    parameter int          TUBE_SPACING = 400,
    parameter int          GAP_MIN      = 80,
    parameter int          GAP_RANGE    = 480,
    parameter int          BIRD_X       = 180,
    parameter int          SPEED_INIT   = 2,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        freeze,
    output logic [10:0] tube_x [3],
    output logic [10:0] gap_y [3],
    output logic        score_pulse,
    output logic        running
);
    localparam logic [11:0] SPACING12 = 12'(TUBE_SPACING);
    localparam logic [11:0] WIDTH12   = 12'(TUBE_WIDTH);
    localparam logic [11:0] BIRD12    = 12'(BIRD_X);
    localparam logic [9:0]  RANGE10   = 10'(GAP_RANGE);
    localparam logic [10:0] GMIN11    = 11'(GAP_MIN);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, FROZEN} state_t;

    state_t      state, state_nx;
    logic [1:0]  load_k;
    logic [15:0] lfsr;
    logic [2:0]  speed;
    logic [11:0] dec [3];
    logic [10:0] x_new [3];
    logic [2:0]  recyc;
    logic [2:0]  hit;
    logic        do_scroll;
    logic [10:0] new_gap;

    function automatic logic [10:0] gap_of(input logic [8:0] l);
        logic [9:0] r;
        r = {1'b0, l};
        if (r >= RANGE10) r = r - RANGE10;
        return GMIN11 + {1'b0, r};
    endfunction

    assign new_gap   = gap_of(lfsr[8:0]);
    // A start or freeze in the same cycle pre-empts the scroll.
    assign do_scroll = (state == RUN) && frame_tick && !start && !freeze;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    if (load_k == 2'd2) state_nx = RUN;
            RUN: begin
                if (start)       state_nx = LOAD;
                else if (freeze) state_nx = FROZEN;
            end
            FROZEN: begin
                if (start)        state_nx = LOAD;
                else if (!freeze) state_nx = RUN;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Spacing exceeds speed, so the predecessor slot is never the recycled one.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            dec[k]   = {1'b0, tube_x[k]} - {9'd0, speed};
            recyc[k] = {1'b0, tube_x[k]} < {9'd0, speed};
        end
        for (int k = 0; k < 3; k++) begin
            x_new[k] = recyc[k] ? 11'(dec[(k + 2) % 3] + SPACING12) : 11'(dec[k]);
            hit[k]   = !recyc[k] && (({1'b0, tube_x[k]} + WIDTH12) > BIRD12)
                       && ((dec[k] + WIDTH12) <= BIRD12);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            load_k      <= 2'd0;
            lfsr        <= LFSR_SEED;
            score_pulse <= 1'b0;
            running     <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                tube_x[k] <= 11'h7FF;
                gap_y[k]  <= GMIN11;
            end
        end else begin
            state       <= state_nx;
            lfsr        <= lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
            running     <= (state_nx == RUN);
            score_pulse <= do_scroll && (|hit);
            load_k      <= (state == LOAD) ? load_k + 2'd1 : 2'd0;
            if (state == LOAD) begin
                tube_x[load_k] <= 11'(SCREEN_W + int'(load_k) * TUBE_SPACING);
                gap_y[load_k]  <= new_gap;
            end else if (do_scroll) begin
                for (int k = 0; k < 3; k++) begin
                    tube_x[k] <= x_new[k];
                    if (recyc[k]) gap_y[k] <= new_gap;
                end
            end
        end
    end

`ifdef TUBE_SPEEDUP_EN
    logic [3:0] score_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed     <= 3'(SPEED_INIT);
            score_cnt <= 4'd0;
        end else if (state != LOAD && state_nx == LOAD) begin
            speed     <= 3'(SPEED_INIT);
            score_cnt <= 4'd0;
        end else if (do_scroll && (|hit)) begin
            if (score_cnt == 4'd7) begin
                score_cnt <= 4'd0;
                if (speed < 3'd6) speed <= speed + 3'd1;
            end else begin
                score_cnt <= score_cnt + 4'd1;
            end
        end
    end
`else
    assign speed = 3'(SPEED_INIT);
`endif

endmodule

// File: tb/tb_tube_scheduler.sv
// Bench for tube_scheduler: phase/position model checked every cycle plus directed literal checks.
module tb_tube_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic        freeze = 1'b0;
    logic [10:0] tube_x [3];
    logic [10:0] gap_y [3];
    logic        score_pulse;
    logic        running;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    tube_scheduler dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start), .freeze(freeze),
        .tube_x(tube_x), .gap_y(gap_y), .score_pulse(score_pulse), .running(running)
    );

    localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_FROZEN = 3;

    int          m_phase, m_ld;
    int          m_x[3];
    int          m_g[3];
    int unsigned m_lfsr;
    bit          m_pulse, m_run;

    function automatic int gap_model(int unsigned l);
        int r;
        r = int'(l % 512);
        if (r >= 480) r -= 480;
        return 80 + r;
    endfunction

    // Model: a recycled tube goes 400 px behind the farthest remaining tube.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = P_IDLE; m_ld = 0; m_lfsr = 32'hACE1; m_pulse = 0; m_run = 0;
            for (int k = 0; k < 3; k++) begin m_x[k] = 2047; m_g[k] = 80; end
        end else begin
            int g, rec, far, hits;
            int nx[3];
            g = gap_model(m_lfsr);
            m_lfsr = (m_lfsr & 1) ? ((m_lfsr >> 1) ^ 32'hB400) : (m_lfsr >> 1);
            m_pulse = 0;
            case (m_phase)
                P_IDLE: if (start) begin m_phase = P_LOAD; m_ld = 0; end
                P_LOAD: begin
                    m_x[m_ld] = 1024 + 400 * m_ld;
                    m_g[m_ld] = g;
                    m_ld++;
                    if (m_ld == 3) m_phase = P_RUN;
                end
                P_RUN: begin
                    if (start) begin m_phase = P_LOAD; m_ld = 0; end
                    else if (freeze) m_phase = P_FROZEN;
                    else if (frame_tick) begin
                        rec = -1; far = 0; hits = 0;
                        for (int k = 0; k < 3; k++) begin
                            if (m_x[k] < 2) begin
                                rec = k; nx[k] = 0;
                            end else begin
                                nx[k] = m_x[k] - 2;
                                if (nx[k] > far) far = nx[k];
                                if (m_x[k] + 120 > 180 && nx[k] + 120 <= 180) hits++;
                            end
                        end
                        if (rec >= 0) begin nx[rec] = far + 400; m_g[rec] = g; end
                        m_x = nx;
                        m_pulse = (hits > 0);
                    end
                end
                default: begin
                    if (start) begin m_phase = P_LOAD; m_ld = 0; end
                    else if (!freeze) m_phase = P_RUN;
                end
            endcase
            m_run = (m_phase == P_RUN);
        end
    end

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("model tube_x[%0d]", k), int'(tube_x[k]), m_x[k]);
                chk($sformatf("model gap_y[%0d]", k), int'(gap_y[k]), m_g[k]);
            end
            chk("model score_pulse", int'(score_pulse), int'(m_pulse));
            chk("model running", int'(running), int'(m_run));
        end
    end

    int ticks = 0;
    int pulses = 0;
    int pulse_tick = -1;
    int first_gap[3];
    int x0[3];

    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        ticks++;
        if (score_pulse) begin pulses++; pulse_tick = ticks; end
        @(negedge clk);
    endtask

    task automatic idle_warmup();
        freeze = 1'b1; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0; freeze = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_loaded(input string tag);
        chk({tag, " running"}, int'(running), 1);
        chk({tag, " tube_x[0]"}, int'(tube_x[0]), 1024);
        chk({tag, " tube_x[1]"}, int'(tube_x[1]), 1424);
        chk({tag, " tube_x[2]"}, int'(tube_x[2]), 1824);
        for (int k = 0; k < 3; k++)
            chk($sformatf("%s gap_y[%0d] in range", tag, k),
                int'(gap_y[k] >= 11'd80 && gap_y[k] <= 11'd559), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("reset tube_x", int'(tube_x[k]), 2047);
            chk("reset gap_y", int'(gap_y[k]), 80);
        end
        chk("reset running", int'(running), 0);
        chk("reset score_pulse", int'(score_pulse), 0);

        idle_warmup();
        chk("idle tick ignored tube_x[0]", int'(tube_x[0]), 2047);
        chk("idle running", int'(running), 0);

        do_start();
        chk_loaded("load");
        for (int k = 0; k < 3; k++) first_gap[k] = int'(gap_y[k]);

        tick();
        chk("tick1 tube_x[0]", int'(tube_x[0]), 1022);
        chk("tick1 tube_x[1]", int'(tube_x[1]), 1422);
        chk("tick1 tube_x[2]", int'(tube_x[2]), 1822);
        repeat (512) tick();
        chk("tick513 tube_x[0]", int'(tube_x[0]), 1198);
        chk("tick513 tube_x[1]", int'(tube_x[1]), 398);
        chk("tick513 tube_x[2]", int'(tube_x[2]), 798);
        chk("tick513 gap_y[0] in range", int'(gap_y[0] >= 11'd80 && gap_y[0] <= 11'd559), 1);
        chk("score pulse count", pulses, 1);
        chk("score pulse tick", pulse_tick, 482);

        freeze = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) x0[k] = int'(tube_x[k]);
        chk("frozen running", int'(running), 0);
        repeat (10) tick();
        for (int k = 0; k < 3; k++) chk("frozen tube_x hold", int'(tube_x[k]), x0[k]);
        chk("frozen running after ticks", int'(running), 0);
        freeze = 1'b0;
        @(negedge clk);
        chk("unfreeze running", int'(running), 1);
        tick();
        for (int k = 0; k < 3; k++) chk("unfreeze scroll", int'(tube_x[k]), x0[k] - 2);

        freeze = 1'b1;
        @(negedge clk);
        do_start();
        chk_loaded("restart from frozen");
        freeze = 1'b0;
        repeat (3) tick();

        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("async reset tube_x", int'(tube_x[k]), 2047);
            chk("async reset gap_y", int'(gap_y[k]), 80);
        end
        chk("async reset running", int'(running), 0);
        chk("async reset score_pulse", int'(score_pulse), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        idle_warmup();
        freeze = 1'b1;
        do_start();
        chk_loaded("start+freeze in idle");
        for (int k = 0; k < 3; k++) chk("lfsr reseeded gap", int'(gap_y[k]), first_gap[k]);
        @(negedge clk);
        chk("freeze honoured in run", int'(running), 0);
        freeze = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
